// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory arbiter
package dmem_pkg;

    localparam int DMEM_ADDR_W   = 32;
    localparam int DMEM_DATA_W   = 32;
    localparam int IO_WINDOW_BIT = 31;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arb_policy.sv
// rtl/dmem_arb_policy.sv - contested-cycle winner select; DMEM_ARB_RR_EN selects round-robin
// instead of fixed priority with m1 starvation protection.
module dmem_arb_policy
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m1_req,
    input  logic contested,
    input  logic m0_gnt,
    input  logic m1_gnt,
    output logic m1_wins
);

`ifdef DMEM_ARB_RR_EN
    // Pointer names the requester that should win the next contested cycle.
    logic ptr;
    logic unused_rr;

    assign unused_rr = m1_req ^ contested;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= M0;
        end else if (m0_gnt) begin
            ptr <= M1;
        end else if (m1_gnt) begin
            ptr <= M0;
        end
    end

    assign m1_wins = (ptr == M1);
`else
    logic [7:0] starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= 8'd0;
        end else if (m1_gnt || !m1_req) begin
            starve <= 8'd0;
        end else if (contested && m0_gnt && (starve != 8'(STARVE_MAX))) begin
            starve <= starve + 8'd1;
        end
    end

    assign m1_wins = (starve == 8'(STARVE_MAX));
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of DMEM: FSM, request mux and read response.
// Build option DMEM_ARB_RR_EN (see dmem_arb_policy) selects round-robin arbitration.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state;
    arb_state_t        state_n;
    logic              arb_now;
    logic              contested;
    logic              m1_wins;
    logic              rd_pend;
    logic              rd_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // LOCK1 falls back to normal arbitration in the very cycle m1_lock drops.
    assign arb_now   = (state == ARB) || !m1_lock;
    assign contested = arb_now && m0_req && m1_req;

    dmem_arb_policy #(
        .STARVE_MAX (STARVE_MAX)
    ) u_policy (
        .clk       (clk),
        .rst_n     (rst_n),
        .m1_req    (m1_req),
        .contested (contested),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m1_wins   (m1_wins)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ARB:     if (m1_gnt && m1_lock) state_n = LOCK1;
            LOCK1:   if (!m1_lock) state_n = ARB;
            default: state_n = ARB;
        endcase
    end

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!arb_now) begin
            m1_gnt = m1_req;
        end else if (contested) begin
            m0_gnt = !m1_wins;
            m1_gnt = m1_wins;
        end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
        end
    end

    // Idle cycles keep presenting the last granted address and data.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= M0;
        end else begin
            if (m0_gnt || m1_gnt) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            rd_pend  <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            rd_owner <= m1_gnt ? M1 : M0;
        end
    end

    assign m0_rvalid = rd_pend && (rd_owner == M0);
    assign m1_rvalid = rd_pend && (rd_owner == M1);
    assign m0_rdata  = rd_pend ? mem_rdata : '0;
    assign m1_rdata  = rd_pend ? mem_rdata : '0;
    assign busy      = (state == LOCK1) || rd_pend;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural DMEM
module tb_dmem_arbiter;

    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // DMEM: 256-word BRAM plus an IO register (toss_cnt) at 0x80000008.
    logic [31:0] bram [256];
    logic [31:0] toss_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
            toss_cnt  <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if (mem_we) begin
                if (mem_addr[31]) begin
                    if (mem_addr[7:0] == 8'h08) toss_cnt <= mem_wdata;
                end else begin
                    bram[mem_addr[9:2]] <= mem_wdata;
                end
            end
            mem_rdata <= mem_addr[31] ? toss_cnt : bram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic lk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r0, w0, r1, w1, lk;
        logic [31:0] a0, a1;
        logic        eg0, eg1, ewe;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [7];

    // reference-model state for the random phase
    bit          locked;
    int          starve;
    bit          pref1;
    bit          pv0, pv1;
    logic [31:0] pdata;
    logic [31:0] shadow [256];

    initial begin
        logic expect_m1;

        // ---- reset and idle ----
        do_reset();
        #1;
        chk("rst_gnt",    {m0_gnt, m1_gnt}, 2'b00);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        chk("rst_rdata",  {m0_rdata, m1_rdata}, 64'd0);
        chk("rst_mem",    {mem_we, mem_addr}, 33'd0);
        chk("rst_wdata",  mem_wdata, 0);
        chk("rst_busy",   busy, 0);

        // ---- m0 reads 0x100 ----
        @(negedge clk);
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rd100_gnt",  {m0_gnt, m1_gnt}, 2'b10);
        chk("rd100_addr", mem_addr, 32'h100);
        @(negedge clk);
        idle();
        #1;
        chk("rd100_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("rd100_rdata",  m0_rdata, init_word(64));
        chk("rd100_busy",   busy, 1);

        // ---- single-cycle vectors, idle cycle between each ----
        expect_m1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
        expect_m1 = 1'b1;
`endif
        vecs[0] = '{0,0,0,0,0, 32'h0,  32'h0,  0,0,0, 32'h100};
        vecs[1] = '{0,0,1,0,0, 32'h0,  32'h40, 0,1,0, 32'h40};
        vecs[2] = '{1,1,0,0,0, 32'h44, 32'h0,  1,0,1, 32'h44};
        vecs[3] = '{1,0,1,0,0, 32'h48, 32'h4C, !expect_m1, expect_m1, 0,
                    expect_m1 ? 32'h4C : 32'h48};
        vecs[4] = '{1,1,1,1,0, 32'h50, 32'h54, 1,0,1, 32'h50};
        vecs[5] = '{0,0,1,1,0, 32'h0,  32'h58, 0,1,1, 32'h58};
        vecs[6] = '{1,0,0,0,1, 32'h5C, 32'h0,  1,0,0, 32'h5C};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, 32'hD0 + 32'(i),
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, 32'hE0 + 32'(i), vecs[i].lk);
            #1;
            chk($sformatf("vec%0d_gnt", i), {m0_gnt, m1_gnt}, {vecs[i].eg0, vecs[i].eg1});
            chk($sformatf("vec%0d_mem", i), {mem_we, mem_addr}, {vecs[i].ewe, vecs[i].eaddr});
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("vec%0d_hold", i), {mem_we, mem_addr}, {1'b0, vecs[i].eaddr});
        end

        // ---- continuous contention ----
        do_reset();
        for (int i = 0; i < 18; i++) begin
`ifdef DMEM_ARB_RR_EN
            expect_m1 = (i % 2) == 1;
`else
            expect_m1 = (i % 9) == 8;
`endif
            drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0);
            #1;
            chk($sformatf("cont%0d", i), {m0_gnt, m1_gnt}, {!expect_m1, expect_m1});
            @(negedge clk);
        end
        idle();

        // ---- m1 locked burst ----
        do_reset();
        begin
            logic [5:0] lk_r1 = 6'b011011;
            logic [5:0] lk_r0 = 6'b111110;
            logic [5:0] lk_lk = 6'b011111;
            logic [5:0] lk_g0 = 6'b100000;
            logic [5:0] lk_g1 = 6'b011011;
            logic [31:0] lk_a [6] = '{32'h8000_0008, 32'h20, 32'h0, 32'h24, 32'h28, 32'h0};
            for (int i = 0; i < 6; i++) begin
                drive(lk_r0[i], 0, 32'h30, 0, lk_r1[i], 1, lk_a[i], (i == 0) ? 32'd5 : 32'h70 + 32'(i),
                      lk_lk[i]);
                #1;
                chk($sformatf("lock%0d_gnt", i), {m0_gnt, m1_gnt}, {lk_g0[i], lk_g1[i]});
                if (i >= 1) chk($sformatf("lock%0d_busy", i), busy, 1);
                @(negedge clk);
            end
            idle();
            #1;
            chk("lock_toss_cnt", toss_cnt, 5);
            chk("lock_bram20",   bram[8], 32'h71);
            chk("lock_m0_rvalid", m0_rvalid, 1);
        end

        // ---- back-to-back read, read, write ----
        do_reset();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        #1;
        chk("b2b0_gnt", {m0_gnt, m1_gnt}, 2'b10);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 32'h14, 0, 0);
        #1;
        chk("b2b1_gnt",    {m0_gnt, m1_gnt}, 2'b01);
        chk("b2b1_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("b2b1_rdata",  m0_rdata, init_word(4));
        @(negedge clk);
        drive(1, 1, 32'h10, 32'h1234, 0, 0, 0, 0, 0);
        #1;
        chk("b2b2_gnt",    {m0_gnt, m1_gnt, mem_we}, 3'b101);
        chk("b2b2_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
        chk("b2b2_rdata",  m1_rdata, init_word(5));
        @(negedge clk);
        idle();
        #1;
        chk("b2b3_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        chk("b2b3_bram",   bram[4], 32'h1234);

        // ---- async reset with a read response pending ----
        @(negedge clk);
        drive(1, 0, 32'h18, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {m0_rvalid, m1_rvalid, busy}, 3'b000);
        repeat (2) @(negedge clk);
        chk("arst_hold", {m0_rvalid, m1_rvalid, busy}, 3'b000);
        rst_n = 1'b1;
        #1;
        chk("arst_after", {m0_rvalid, m1_rvalid, busy}, 3'b000);
        @(negedge clk);
        drive(1, 0, 32'h1C, 0, 0, 0, 0, 0, 0);
        #1;
        chk("arst_state_arb", {m0_gnt, m1_gnt}, 2'b10);

        // ---- randomized traffic against the reference model ----
        do_reset();
        locked = 0; starve = 0; pref1 = 0; pv0 = 0; pv1 = 0; pdata = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        for (int c = 0; c < 400; c++) begin
            logic r0, r1, w0, w1, lk, g0, g1, arb;
            logic [31:0] a0, a1, d0, d1;
            r0 = 1'($urandom % 2); r1 = 1'($urandom % 2);
            w0 = 1'($urandom % 2); w1 = 1'($urandom % 2);
            a0 = 32'($urandom % 16) << 2; a1 = 32'($urandom % 16) << 2;
            d0 = $urandom; d1 = $urandom;
            lk = locked ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);

            arb = !locked || !lk;
            if (!arb) begin
                g0 = 0; g1 = r1;
            end else if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
                g1 = pref1;
`else
                g1 = (starve == SM);
`endif
                g0 = !g1;
            end else begin
                g0 = r0; g1 = r1;
            end
            #1;
            chk("rnd_gnt",    {m0_gnt, m1_gnt}, {g0, g1});
            chk("rnd_rvalid", {m0_rvalid, m1_rvalid}, {pv0, pv1});
            if (pv0) chk("rnd_rdata0", m0_rdata, pdata);
            if (pv1) chk("rnd_rdata1", m1_rdata, pdata);
            chk("rnd_busy", busy, locked || pv0 || pv1);
            if (g0 || g1) begin
                chk("rnd_mem", {mem_we, mem_addr}, g0 ? {w0, a0} : {w1, a1});
                if (g0 ? w0 : w1) chk("rnd_wdata", mem_wdata, g0 ? d0 : d1);
            end else begin
                chk("rnd_idle_we", mem_we, 0);
            end

            pv0 = g0 && !w0;
            pv1 = g1 && !w1;
            if (g0) pdata = shadow[a0[9:2]];
            if (g1) pdata = shadow[a1[9:2]];
            if (g0 && w0) shadow[a0[9:2]] = d0;
            if (g1 && w1) shadow[a1[9:2]] = d1;
            if (g1 || !r1) starve = 0;
            else if (r0 && r1 && g0 && starve < SM) starve++;
            if (g0) pref1 = 1;
            else if (g1) pref1 = 0;
            locked = arb ? (g1 && lk) : 1'b1;
            @(negedge clk);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port (BRAM plus the bit-31 memory-mapped IO window) between the CPU load/store unit (m0) and the program-loader/debug requester (m1). Sits between both requesters and the DMEM block. Grants one access per cycle, forwards it to DMEM, and returns read data one cycle later to the requester that issued the read. Supports a locked burst mode for m1 and starvation protection for m1 under fixed priority.

## Interface
- ADDR_W, 32, address width (bit 31 selects the IO window)
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive contested cycles m1 may lose before it is force-granted (fixed-priority mode only), range 1..255
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m1_lock  in  1  m1 keeps ownership across consecutive cycles while high
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  read data, meaningful only with rvalid
- mem_we  out  1  to DMEM we
- mem_addr  out  ADDR_W  to DMEM ask_addr and fetch_addr
- mem_wdata  out  DATA_W  to DMEM wdata
- mem_rdata  in  DATA_W  from DMEM rdata, valid one cycle after address
- busy  out  1  high while state is LOCK1 or a read response is pending

## Operation
- FSM states: ARB, LOCK1. Reset state ARB.
- ARB: one requester → grant it. Both → policy winner (see Configuration). Granted m1 with m1_lock=1 → LOCK1 next cycle.
- LOCK1: m1 is the only candidate; m0_gnt=0. m1_gnt=m1_req. Exit to ARB on the first cycle m1_lock=0. That cycle is arbitrated normally.
- Mux: mem_addr/mem_wdata/mem_we come from the granted requester. No grant → mem_we=0, address holds the last granted value.
- Writes complete in the grant cycle. No response is returned.
- Reads: register rd_pend=1 and rd_owner on grant. Next cycle, assert the owner's rvalid for exactly 1 cycle. m0_rdata and m1_rdata both carry mem_rdata.
- Starvation counter (fixed mode): increments when both request and m0 wins; clears on any m1 grant or when m1_req=0; saturates. Counter == STARVE_MAX → m1 wins the next contested cycle.
- Reset values: all gnt 0, all rvalid 0, rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, rd_pend 0, starve 0, rr pointer → m0, state ARB.

## Timing
- Grant latency 0 cycles (combinational from req, state, and policy registers).
- Read latency 1 cycle from grant to rvalid. Back-to-back reads are allowed at one per cycle, with no bubble.
- Read granted on cycle N, write granted on N+1: the rvalid for the read still appears on N+1, unaffected.
- Async reset mid-read: the pending rvalid is dropped. Never emitted after reset.
- m1_lock asserted without a grant has no effect.
- Requester drops req without being granted: legal. Nothing is forwarded.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. A contested cycle goes to the requester not granted most recently; the pointer updates on every grant. The starvation counter is not built. STARVE_MAX is ignored.
- Undefined: fixed priority. m0 wins contested cycles, subject to the STARVE_MAX rule.
- LOCK1 behaves identically in both builds.

## Structure
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, the IO_WINDOW_BIT=31 constant, the arb_state_t enum (ARB, LOCK1), and the requester ID constants M0=0 and M1=1.
- One sub-module, dmem_arb_policy: winner select, rr pointer, and starvation counter. It owns the ifdef.
- The top level holds the FSM, the mux, and the response registers.

## Test plan
- Reset then idle: all outputs 0, busy 0. m0 reads 0x100 → m0_gnt same cycle; m0_rvalid next cycle with the BRAM word.
- Contention, fixed build: both request continuously. m0 granted 8 cycles, m1 granted the 9th, counter back to 0.
- Contention, RR build: both request continuously. Grants alternate m0, m1, m0, m1.
- Lock: m1 writes 0x80000008=5 with m1_lock=1, then 3 more writes while m0 requests. m0_gnt stays 0 for 4 cycles and is granted the cycle after m1_lock falls. DMEM toss_cnt=5.
- Back-to-back: m0 reads 0x10, m1 reads 0x14, m0 writes 0x10 on consecutive cycles. rvalid goes m0 then m1 on consecutive cycles with correct data. The write produces no rvalid.
- Async reset in the cycle after a read grant: no rvalid appears. State is ARB and busy is 0 after release.
